// File: rtl/alu_uart_pkg.sv
// Shared constants for the UART-to-ALU glue stage:
// ALU opcodes, FSM state codes and default widths.
package alu_uart_pkg;

  localparam int DEF_SIZEDATA = 8;
  localparam int DEF_SIZEOP   = 6;

  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_NOR = 6'b100111;
  localparam logic [5:0] OP_SRA = 6'b000011;
  localparam logic [5:0] OP_SRL = 6'b000010;

  localparam int ST_W = 3;

  localparam logic [ST_W-1:0] ST_IDLE    = 3'd0;
  localparam logic [ST_W-1:0] ST_WAIT_B  = 3'd1;
  localparam logic [ST_W-1:0] ST_WAIT_OP = 3'd2;
  localparam logic [ST_W-1:0] ST_CALC    = 3'd3;
  localparam logic [ST_W-1:0] ST_SEND    = 3'd4;
  localparam logic [ST_W-1:0] ST_WAIT_TX = 3'd5;

  // States in which the inter-byte timeout counter is live
  function automatic logic st_waiting(
    input logic [ST_W-1:0] s
  );
    return (s == ST_WAIT_B) || (s == ST_WAIT_OP);
  endfunction

endpackage

// File: rtl/rise_detect.sv
// One-bit rising-edge detector with a single
// prior-sample register.
module rise_detect (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic rise_o
);

  logic d_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      d_q <= 1'b0;
    end else begin
      d_q <= d_i;
    end
  end

  assign rise_o = d_i & ~d_q;

endmodule

// File: rtl/alu_uart_interface.sv
// Collects A, B and opcode bytes from the UART, runs the ALU
// and hands the result to the UART transmitter.
module alu_uart_interface
  import alu_uart_pkg::*;
#(
  parameter int          SIZEDATA       = DEF_SIZEDATA,
  parameter int          SIZEOP         = DEF_SIZEOP,
  parameter int unsigned TIMEOUT_CYCLES = 65535,
  parameter int          TO_WIDTH       = 16
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_rx_done,
  input  logic [SIZEDATA-1:0] i_rx_data,
  input  logic [SIZEDATA-1:0] i_alu_result,
  input  logic                i_tx_done,
  output logic [SIZEDATA-1:0] o_alu_a,
  output logic [SIZEDATA-1:0] o_alu_b,
  output logic [SIZEOP-1:0]   o_alu_op,
  output logic                o_tx_signal,
  output logic [SIZEDATA-1:0] o_tx_data,
  output logic                o_busy,
  output logic                o_timeout,
  output logic                o_drop
);

  localparam logic [TO_WIDTH-1:0] TO_LAST =
    TO_WIDTH'(TIMEOUT_CYCLES - 1);

  logic rx_ev;
  logic tx_ev;

  rise_detect u_rx_rise (
    .clk_i  (i_clock),
    .rst_ni (i_reset),
    .d_i    (i_rx_done),
    .rise_o (rx_ev)
  );

  rise_detect u_tx_rise (
    .clk_i  (i_clock),
    .rst_ni (i_reset),
    .d_i    (i_tx_done),
    .rise_o (tx_ev)
  );

  logic [ST_W-1:0]     state_q, state_d;
  logic [SIZEDATA-1:0] a_q, a_d;
  logic [SIZEDATA-1:0] b_q, b_d;
  logic [SIZEOP-1:0]   op_q, op_d;
  logic [SIZEDATA-1:0] res_q, res_d;
  logic [TO_WIDTH-1:0] cnt_q, cnt_d;
  logic                to_q, to_d;
  logic                drop_q, drop_d;
  logic                waiting;
  logic                expire;

  assign waiting = st_waiting(state_q);

  // A byte arriving on the last count wins over the timeout
  assign expire = (TIMEOUT_CYCLES != 0) && waiting &&
                  !rx_ev && (cnt_q == TO_LAST);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    res_d   = res_q;
    to_d    = 1'b0;
    drop_d  = 1'b0;
    cnt_d   = '0;

    if (waiting && !rx_ev && !expire) begin
      cnt_d = cnt_q + TO_WIDTH'(1);
    end

    unique case (state_q)
      ST_IDLE: begin
        if (rx_ev) begin
          a_d     = i_rx_data;
          state_d = ST_WAIT_B;
        end
      end
      ST_WAIT_B: begin
        if (rx_ev) begin
          b_d     = i_rx_data;
          state_d = ST_WAIT_OP;
        end else if (expire) begin
          to_d    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_WAIT_OP: begin
        if (rx_ev) begin
          op_d    = i_rx_data[SIZEOP-1:0];
          state_d = ST_CALC;
        end else if (expire) begin
          to_d    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_CALC: begin
        drop_d  = rx_ev;
        res_d   = i_alu_result;
        state_d = ST_SEND;
      end
      ST_SEND: begin
        drop_d  = rx_ev;
        state_d = ST_WAIT_TX;
      end
      ST_WAIT_TX: begin
        drop_d = rx_ev;
        if (tx_ev) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      to_q    <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
      drop_q  <= drop_d;
    end
  end

  assign o_alu_a     = a_q;
  assign o_alu_b     = b_q;
  assign o_alu_op    = op_q;
  assign o_tx_data   = res_q;
  assign o_tx_signal = (state_q == ST_SEND);
  assign o_busy      = (state_q != ST_IDLE);
  assign o_timeout   = to_q;
  assign o_drop      = drop_q;

endmodule

// File: tb/tb_alu_uart_interface.sv
// Scoreboard bench: stimulus queues expected DUT events,
// a negedge monitor pops and compares them.
module tb_alu_uart_interface;
  import alu_uart_pkg::*;

  localparam int EV_TX   = 0;
  localparam int EV_TO   = 1;
  localparam int EV_DROP = 2;

  typedef struct {
    int         kind;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] op;
    logic [7:0] d;
    int         cyc;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       rx_done;
  logic [7:0] rx_data;
  logic [7:0] alu_res;
  logic       tx_done;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [5:0] alu_op;
  logic       tx_sig;
  logic [7:0] tx_data;
  logic       busy;
  logic       tmo;
  logic       drop;

  exp_t sbq[$];
  int   cyc = 0;
  int   checks = 0;
  int   passed = 0;

  alu_uart_interface #(
    .SIZEDATA       (8),
    .SIZEOP         (6),
    .TIMEOUT_CYCLES (100),
    .TO_WIDTH       (16)
  ) dut (
    .i_clock      (clk),
    .i_reset      (rst_n),
    .i_rx_done    (rx_done),
    .i_rx_data    (rx_data),
    .i_alu_result (alu_res),
    .i_tx_done    (tx_done),
    .o_alu_a      (alu_a),
    .o_alu_b      (alu_b),
    .o_alu_op     (alu_op),
    .o_tx_signal  (tx_sig),
    .o_tx_data    (tx_data),
    .o_busy       (busy),
    .o_timeout    (tmo),
    .o_drop       (drop)
  );

  function automatic logic [7:0] alu_model(
    input logic [7:0] a,
    input logic [7:0] b,
    input logic [5:0] op
  );
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_NOR:  return ~(a | b);
      OP_SRA:  return $signed(a) >>> b;
      OP_SRL:  return a >> b;
      default: return 8'h00;
    endcase
  endfunction

  assign alu_res = alu_model(alu_a, alu_b, alu_op);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(
    input string       name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic pop_check(input int kind);
    exp_t e;
    if (sbq.size() == 0) begin
      checks++;
      $display("FAIL unexpected_event: got kind %0d at cyc %0d expected none",
               kind, cyc);
      return;
    end
    e = sbq.pop_front();
    chk("event_kind", kind, e.kind);
    chk("event_cycle", cyc, e.cyc);
    if (kind == EV_TX && e.kind == EV_TX) begin
      chk("tx_data", {24'd0, tx_data}, {24'd0, e.d});
      chk("alu_a", {24'd0, alu_a}, {24'd0, e.a});
      chk("alu_b", {24'd0, alu_b}, {24'd0, e.b});
      chk("alu_op", {26'd0, alu_op}, {24'd0, e.op});
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (tx_sig) pop_check(EV_TX);
      if (tmo)    pop_check(EV_TO);
      if (drop)   pop_check(EV_DROP);
    end
  end

  task automatic push(
    input int kind, input logic [7:0] a, input logic [7:0] b,
    input logic [7:0] op, input logic [7:0] d, input int c
  );
    exp_t e;
    e.kind = kind; e.a = a; e.b = b;
    e.op = op; e.d = d; e.cyc = c;
    sbq.push_back(e);
  endtask

  task automatic send(input logic [7:0] b, output int c0);
    @(posedge clk); #1;
    rx_data = b;
    rx_done = 1'b1;
    @(posedge clk); #1;
    c0 = cyc;
    rx_done = 1'b0;
  endtask

  task automatic seq(
    input logic [7:0] a, input logic [7:0] b,
    input logic [7:0] opb, input logic [7:0] exp_op,
    input logic [7:0] exp_d
  );
    int c;
    send(a, c);
    send(b, c);
    send(opb, c);
    push(EV_TX, a, b, exp_op, exp_d, c + 1);
  endtask

  task automatic tx_pulse();
    @(posedge clk); #1;
    tx_done = 1'b1;
    @(posedge clk); #1;
    tx_done = 1'b0;
  endtask

  initial begin
    int c;
    rst_n   = 1'b0;
    rx_done = 1'b0;
    rx_data = 8'h00;
    tx_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_alu_a", {24'd0, alu_a}, 32'h0);
    chk("rst_tx_sig", {31'd0, tx_sig}, 32'h0);
    chk("rst_busy", {31'd0, busy}, 32'h0);
    chk("rst_tx_data", {24'd0, tx_data}, 32'h0);
    rst_n = 1'b1;

    // ADD 5 + 3
    seq(8'h05, 8'h03, 8'h20, 8'h20, 8'h08);
    repeat (4) @(posedge clk);
    tx_pulse();
    chk("busy_after_tx1", {31'd0, busy}, 32'h0);

    // Opcode upper bits ignored: 0xE2 -> SUB
    seq(8'h0A, 8'h04, 8'hE2, 8'h22, 8'h06);
    repeat (4) @(posedge clk);
    tx_pulse();
    chk("busy_after_tx2", {31'd0, busy}, 32'h0);

    // Inter-byte timeout
    send(8'h11, c);
    push(EV_TO, 8'h0, 8'h0, 8'h0, 8'h0, c + 100);
    repeat (101) @(posedge clk);
    #1;
    chk("busy_after_to", {31'd0, busy}, 32'h0);
    chk("a_kept_after_to", {24'd0, alu_a}, 32'h11);
    seq(8'h01, 8'h02, 8'h20, 8'h20, 8'h03);
    repeat (4) @(posedge clk);
    tx_pulse();

    // Byte during WAIT_TX is dropped
    seq(8'h07, 8'h02, 8'h24, 8'h24, 8'h02);
    repeat (4) @(posedge clk);
    send(8'h55, c);
    push(EV_DROP, 8'h0, 8'h0, 8'h0, 8'h0, c);
    repeat (2) @(posedge clk);
    #1;
    chk("busy_in_wait_tx", {31'd0, busy}, 32'h1);
    tx_pulse();
    chk("busy_after_drop", {31'd0, busy}, 32'h0);
    chk("tx_data_after_drop", {24'd0, tx_data}, 32'h02);

    // rx_done held high: one byte only
    @(posedge clk); #1;
    rx_data = 8'h7F;
    rx_done = 1'b1;
    @(posedge clk); #1;
    c = cyc;
    push(EV_TO, 8'h0, 8'h0, 8'h0, 8'h0, c + 100);
    repeat (49) @(posedge clk);
    #1;
    rx_done = 1'b0;
    chk("hold_a", {24'd0, alu_a}, 32'h7F);
    chk("hold_b", {24'd0, alu_b}, 32'h02);
    chk("hold_busy", {31'd0, busy}, 32'h1);
    repeat (60) @(posedge clk);
    #1;
    chk("hold_idle", {31'd0, busy}, 32'h0);

    // Async reset mid-sequence
    send(8'h80, c);
    send(8'h03, c);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("arst_a", {24'd0, alu_a}, 32'h0);
    chk("arst_b", {24'd0, alu_b}, 32'h0);
    chk("arst_op", {26'd0, alu_op}, 32'h0);
    chk("arst_tx_data", {24'd0, tx_data}, 32'h0);
    chk("arst_busy", {31'd0, busy}, 32'h0);
    chk("arst_outs", {29'd0, tx_sig, tmo, drop}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seq(8'h80, 8'h03, 8'h03, 8'h03, 8'hF0);
    repeat (4) @(posedge clk);
    tx_pulse();
    chk("busy_final", {31'd0, busy}, 32'h0);

    repeat (5) @(posedge clk);
    #1;
    chk("sb_empty", sbq.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
